// File: rtl/dmem_store_logger.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_store_logger
//  Description : Word-addressed data RAM for the core's data port. Every
//                accepted store is also pushed into a FWFT {address, data}
//                log that a host drains over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_logger #(
    parameter int MEM_WORDS = 64,
    parameter int LOG_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         memwrite,
    input  logic [31:0]                  dataadr,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         overflow,
    output logic                         bad_addr,
    output logic [CNT_W-1:0]             store_cnt
);

    localparam int          c_AW        = $clog2(MEM_WORDS);
    localparam int          c_PW        = $clog2(LOG_DEPTH);
    localparam logic [31:0] c_MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [c_PW:0] c_DEPTH   = (c_PW + 1)'(LOG_DEPTH);

    // ------------------------------------------------------------------
    // Address decode and store qualification
    // ------------------------------------------------------------------
    logic            w_in_range;
    logic            w_aligned;
    logic            w_accept;
    logic            w_reject;
    logic [c_AW-1:0] w_word_idx;

    assign w_in_range = (dataadr < c_MEM_BYTES);
    assign w_aligned  = (dataadr[1:0] == 2'b00);
    assign w_accept   = memwrite && w_aligned && w_in_range;
    assign w_reject   = memwrite && !(w_aligned && w_in_range);
    assign w_word_idx = dataadr[c_AW+1:2];

    // ------------------------------------------------------------------
    // Data RAM: no reset so contents survive a mid-run rst
    // ------------------------------------------------------------------
    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_word_idx] <= writedata;
        end
    end

    // Asynchronous read yields the pre-write word during a same-cycle store
    assign readdata = w_in_range ? r_mem[w_word_idx] : 32'h0;

    // ------------------------------------------------------------------
    // Store log FIFO
    // ------------------------------------------------------------------
    logic [31:0]   r_log_addr [LOG_DEPTH];
    logic [31:0]   r_log_data [LOG_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_count;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    assign w_full = (r_count == c_DEPTH);
    assign w_pop  = (r_count != '0) && log_ready;
    // A full log still accepts a push when a pop frees the head slot
    assign w_push = w_accept && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_log_addr[r_wr_ptr] <= dataadr;
            r_log_data[r_wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PW + 1)'(1);
                2'b01:   r_count <= r_count - (c_PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky status and saturating store counter
    // ------------------------------------------------------------------
    logic             r_overflow;
    logic             r_bad_addr;
    logic [CNT_W-1:0] r_store_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_bad_addr  <= 1'b0;
            r_store_cnt <= '0;
        end else begin
            if (w_accept && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_reject) begin
                r_bad_addr <= 1'b1;
            end
            if (w_accept && (r_store_cnt != {CNT_W{1'b1}})) begin
                r_store_cnt <= r_store_cnt + CNT_W'(1);
            end
        end
    end

    assign log_valid = (r_count != '0);
    assign log_addr  = r_log_addr[r_rd_ptr];
    assign log_data  = r_log_data[r_rd_ptr];
    assign log_count = r_count;
    assign overflow  = r_overflow;
    assign bad_addr  = r_bad_addr;
    assign store_cnt = r_store_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_logger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_store_logger
//  Description : Directed self-checking bench for dmem_store_logger.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_store_logger;

    logic        clk;
    logic        rst;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [3:0]  log_count;
    logic        overflow;
    logic        bad_addr;
    logic [15:0] store_cnt;

    int r_checks = 0;
    int r_errors = 0;

    dmem_store_logger #(
        .MEM_WORDS (64),
        .LOG_DEPTH (8),
        .CNT_W     (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_count (log_count),
        .overflow  (overflow),
        .bad_addr  (bad_addr),
        .store_cnt (store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock with the given inputs; inputs return idle afterwards
    task automatic cycle(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdy);
        memwrite  = we;
        dataadr   = addr;
        writedata = data;
        log_ready = rdy;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        log_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        log_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",    32'(log_valid), 32'd0);
        check("rst_count",    32'(log_count), 32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_bad",      32'(bad_addr),  32'd0);
        check("rst_cnt",      32'(store_cnt), 32'd0);
        rst = 1'b0;

        // ---------------- basic store, log and pop ----------------
        cycle(1'b1, 32'd200, 32'd1, 1'b0);
        check("t1_valid_lat", 32'(log_valid), 32'd1);
        cycle(1'b1, 32'd224, 32'h12345000, 1'b0);
        check("t1_count",  32'(log_count), 32'd2);
        check("t1_head_a", log_addr, 32'd200);
        check("t1_head_d", log_data, 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        check("t1_pop_a",  log_addr, 32'd224);
        check("t1_pop_d",  log_data, 32'h12345000);
        check("t1_pop_cnt", 32'(log_count), 32'd1);
        dataadr = 32'd224;
        #1;
        check("t1_load", readdata, 32'h12345000);
        check("t1_scnt", 32'(store_cnt), 32'd2);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1);
        check("t1_empty_pop", 32'(log_count), 32'd0);
        check("t1_empty_vld", 32'(log_valid), 32'd0);

        // ---------------- rejected stores ----------------
        do_reset();
        cycle(1'b1, 32'd202, 32'hDEADBEEF, 1'b0);
        cycle(1'b1, 32'd256, 32'hCAFEF00D, 1'b0);
        check("t2_bad",   32'(bad_addr),  32'd1);
        check("t2_count", 32'(log_count), 32'd0);
        check("t2_scnt",  32'(store_cnt), 32'd0);
        dataadr = 32'd200;
        #1;
        check("t2_ld200", readdata, 32'd1);
        dataadr = 32'd201;
        #1;
        check("t2_ld201", readdata, 32'd1);
        dataadr = 32'd256;
        #1;
        check("t2_ld256", readdata, 32'd0);

        // ---------------- overflow ----------------
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 32'(4 * i), 32'(i), 1'b0);
        end
        check("t3_count", 32'(log_count), 32'd8);
        check("t3_ovf",   32'(overflow),  32'd1);
        check("t3_scnt",  32'(store_cnt), 32'd9);
        dataadr = 32'd32;
        #1;
        check("t3_mem8", readdata, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_a", log_addr, 32'(4 * i));
            check("t3_drain_d", log_data, 32'(i));
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
        check("t3_drained", 32'(log_count), 32'd0);
        check("t3_ovf_stk", 32'(overflow),  32'd1);

        // ---------------- full with simultaneous push and pop ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(4 * i), 32'(100 + i), 1'b0);
        end
        cycle(1'b1, 32'd36, 32'hA5A5A5A5, 1'b1);
        check("t4_count", 32'(log_count), 32'd8);
        check("t4_ovf",   32'(overflow),  32'd0);
        for (int i = 1; i < 8; i++) begin
            check("t4_drain_a", log_addr, 32'(4 * i));
            check("t4_drain_d", log_data, 32'(100 + i));
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
        check("t4_last_a", log_addr, 32'd36);
        check("t4_last_d", log_data, 32'hA5A5A5A5);
        check("t4_last_c", 32'(log_count), 32'd1);

        // ---------------- read during write ----------------
        memwrite  = 1'b1;
        dataadr   = 32'd200;
        writedata = 32'd7;
        #1;
        check("t5_rdw_old", readdata, 32'd1);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check("t5_rdw_new", readdata, 32'd7);

        // ---------------- mid-stream reset ----------------
        do_reset();
        cycle(1'b1, 32'd3, 32'd0, 1'b0);
        cycle(1'b1, 32'd40, 32'd11, 1'b0);
        cycle(1'b1, 32'd44, 32'd22, 1'b0);
        cycle(1'b1, 32'd48, 32'd33, 1'b0);
        check("t6_pre_cnt", 32'(log_count), 32'd3);
        check("t6_pre_bad", 32'(bad_addr),  32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_vld", 32'(log_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_vld",  32'(log_valid), 32'd0);
        check("t6_cnt",  32'(log_count), 32'd0);
        check("t6_scnt", 32'(store_cnt), 32'd0);
        check("t6_bad",  32'(bad_addr),  32'd0);
        check("t6_ovf",  32'(overflow),  32'd0);
        dataadr = 32'd40;
        #1;
        check("t6_ld40", readdata, 32'd11);
        dataadr = 32'd44;
        #1;
        check("t6_ld44", readdata, 32'd22);
        dataadr = 32'd48;
        #1;
        check("t6_ld48", readdata, 32'd33);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
